// File: rtl/tri_128x16_1r1w_ctl_pkg.sv
// Shared types and constants for the 128x16 1R1W array controller.
package tri_ary_ctl_pkg;

    localparam int unsigned ARY_ENTRIES = 128;
    localparam int unsigned ARY_AW      = 7;
    localparam int unsigned ARY_DW      = 16;

    typedef enum logic {
        INIT,
        RUN
    } ctl_state_t;

    // One read in flight: its valid bit plus any same-cycle write to merge on return.
    typedef struct packed {
        logic              val;
        logic              coll;
        logic [ARY_DW-1:0] bw;
        logic [ARY_DW-1:0] di;
    } rd_stage_t;

endpackage

// File: rtl/tri_128x16_1r1w_ctl_if.sv
// Requester-side bus of the array controller: init control, two write ports, one read port.
interface tri_128x16_1r1w_ctl_if;
    import tri_ary_ctl_pkg::*;

    logic              init_req;
    logic              init_busy;

    logic              wr0_req;
    logic [ARY_AW-1:0] wr0_adr;
    logic [ARY_DW-1:0] wr0_bw;
    logic [ARY_DW-1:0] wr0_di;
    logic              wr0_gnt;

    logic              wr1_req;
    logic [ARY_AW-1:0] wr1_adr;
    logic [ARY_DW-1:0] wr1_bw;
    logic [ARY_DW-1:0] wr1_di;
    logic              wr1_gnt;

    logic              rd_req;
    logic [ARY_AW-1:0] rd_adr;
    logic              rd_rdy;
    logic              rd_val;
    logic [ARY_DW-1:0] rd_data;

    modport master (
        output init_req,
        input  init_busy,
        output wr0_req, wr0_adr, wr0_bw, wr0_di,
        input  wr0_gnt,
        output wr1_req, wr1_adr, wr1_bw, wr1_di,
        input  wr1_gnt,
        output rd_req, rd_adr,
        input  rd_rdy, rd_val, rd_data
    );

    modport slave (
        input  init_req,
        output init_busy,
        input  wr0_req, wr0_adr, wr0_bw, wr0_di,
        output wr0_gnt,
        input  wr1_req, wr1_adr, wr1_bw, wr1_di,
        output wr1_gnt,
        input  rd_req, rd_adr,
        output rd_rdy, rd_val, rd_data
    );

endinterface

// File: rtl/tri_128x16_1r1w_ctl_rd_pipe.sv
// Read-return pipeline: delays read tags to line up with ary_do, merges a colliding write, registers the result.
module tri_ary_rd_pipe
    import tri_ary_ctl_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  rd_stage_t         stage_in,
    input  logic [ARY_DW-1:0] ary_do,
    output logic              rd_val,
    output logic [ARY_DW-1:0] rd_data
);

    rd_stage_t         pipe_q [RD_LAT];
    rd_stage_t         head;
    logic [ARY_DW-1:0] merged;

    // The last stage is aligned with the cycle in which ary_do carries this read's data.
    always_comb begin
        head   = pipe_q[RD_LAT-1];
        merged = ary_do;
        if (head.coll) begin
            merged = (head.di & head.bw) | (ary_do & ~head.bw);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            rd_val  <= 1'b0;
            rd_data <= '0;
        end else begin
            pipe_q[0] <= stage_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            rd_val <= head.val;
            if (head.val) begin
                rd_data <= merged;
            end
        end
    end

endmodule

// File: rtl/tri_128x16_1r1w_ctl.sv
// Controller for a 128x16 1R1W array: init sweep, two-requester write arbitration, pipelined reads.
module tri_128x16_1r1w_ctl
    import tri_ary_ctl_pkg::*;
#(
    parameter logic [ARY_DW-1:0] INIT_VAL   = 16'h0000,
    parameter int unsigned       RD_LAT     = 2,
    parameter int unsigned       STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tri_128x16_1r1w_ctl_if.slave  bus,
    output logic                  ary_wr_act,
    output logic [ARY_AW-1:0]     ary_wr_adr,
    output logic [ARY_DW-1:0]     ary_bw,
    output logic [ARY_DW-1:0]     ary_di,
    output logic                  ary_rd_act,
    output logic [ARY_AW-1:0]     ary_rd_adr,
    input  logic [ARY_DW-1:0]     ary_do
);

    localparam int unsigned       SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_SAT = SW'(STARVE_MAX);
    localparam logic [ARY_AW-1:0] LAST_ADR   = ARY_AW'(ARY_ENTRIES - 1);

    ctl_state_t        state_q, state_d;
    logic [ARY_AW-1:0] init_cnt_q, init_cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wr0_gnt, wr1_gnt;
    logic              rd_acc;
    rd_stage_t         stage_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        starve_d   = starve_q;
        wr0_gnt    = 1'b0;
        wr1_gnt    = 1'b0;
        ary_wr_act = 1'b0;
        ary_wr_adr = bus.wr0_adr;
        ary_bw     = bus.wr0_bw;
        ary_di     = bus.wr0_di;

        case (state_q)
            INIT: begin
                ary_wr_act = 1'b1;
                ary_wr_adr = init_cnt_q;
                ary_bw     = '1;
                ary_di     = INIT_VAL;
                init_cnt_d = init_cnt_q + 1'b1;
                starve_d   = '0;
                if (init_cnt_q == LAST_ADR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // wr1 only overrides wr0 once it has been denied STARVE_MAX cycles in a row.
                if (bus.wr1_req && (starve_q == STARVE_SAT || !bus.wr0_req)) begin
                    wr1_gnt = 1'b1;
                end else if (bus.wr0_req) begin
                    wr0_gnt = 1'b1;
                end

                if (wr1_gnt) begin
                    ary_wr_adr = bus.wr1_adr;
                    ary_bw     = bus.wr1_bw;
                    ary_di     = bus.wr1_di;
                end
                ary_wr_act = (wr0_gnt || wr1_gnt) && (ary_bw != '0);

                if (bus.wr1_req && !wr1_gnt) begin
                    starve_d = (starve_q == STARVE_SAT) ? starve_q : starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end

                if (bus.init_req) begin
                    state_d    = INIT;
                    init_cnt_d = '0;
                    starve_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign bus.wr0_gnt   = wr0_gnt;
    assign bus.wr1_gnt   = wr1_gnt;
    assign bus.init_busy = (state_q == INIT);
    assign bus.rd_rdy    = (state_q != INIT);

    assign rd_acc     = bus.rd_req && (state_q == RUN);
    assign ary_rd_act = rd_acc;
    assign ary_rd_adr = bus.rd_adr;

    // Same-cycle write to the read address is carried along and merged over ary_do on return.
    always_comb begin
        stage_in      = '0;
        stage_in.val  = rd_acc;
        stage_in.coll = rd_acc && ary_wr_act && (ary_wr_adr == bus.rd_adr);
        stage_in.bw   = ary_bw;
        stage_in.di   = ary_di;
    end

    tri_ary_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .stage_in (stage_in),
        .ary_do   (ary_do),
        .rd_val   (bus.rd_val),
        .rd_data  (bus.rd_data)
    );

endmodule

// File: tb/tb_tri_128x16_1r1w_ctl.sv
// Self-checking bench: array model plus a shadow-memory reference, directed scenarios and random traffic.
module tb_tri_128x16_1r1w_ctl;
    import tri_ary_ctl_pkg::*;

    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam logic [15:0] INIT_VAL   = 16'h0000;
    localparam int          MAXC       = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        ary_wr_act;
    logic [6:0]  ary_wr_adr;
    logic [15:0] ary_bw;
    logic [15:0] ary_di;
    logic        ary_rd_act;
    logic [6:0]  ary_rd_adr;
    logic [15:0] ary_do;

    tri_128x16_1r1w_ctl_if bus ();

    tri_128x16_1r1w_ctl #(
        .INIT_VAL   (INIT_VAL),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .ary_wr_act (ary_wr_act),
        .ary_wr_adr (ary_wr_adr),
        .ary_bw     (ary_bw),
        .ary_di     (ary_di),
        .ary_rd_act (ary_rd_act),
        .ary_rd_adr (ary_rd_adr),
        .ary_do     (ary_do)
    );

    always #5 clk = ~clk;

    // Behavioural 1R1W array: old data on read-during-write, data out RD_LAT cycles after the read.
    logic [15:0] ary_mem [128];
    logic [15:0] dq [RD_LAT];

    always @(posedge clk) begin
        dq[0] <= ary_mem[ary_rd_adr];
        for (int i = 1; i < int'(RD_LAT); i++) dq[i] <= dq[i-1];
        if (ary_wr_act) ary_mem[ary_wr_adr] <= (ary_mem[ary_wr_adr] & ~ary_bw) | (ary_di & ary_bw);
    end
    assign ary_do = dq[RD_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int          init_left;
    int          deny;
    logic [15:0] shadow [128];
    bit          exp_vld [MAXC];
    logic [15:0] exp_dat [MAXC];
    bit          m_g0, m_g1, dut_g1;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_future();
        for (int i = cyc; i < MAXC; i++) exp_vld[i] = 1'b0;
    endtask

    // One checked clock cycle: inputs are already applied; compare at negedge, advance to posedge+1.
    task automatic tick();
        bit          busy, wact, racc;
        logic [6:0]  wa;
        logic [15:0] wb, wd;
        @(negedge clk);
        busy = (init_left > 0);
        check_eq("init_busy", 16'(bus.init_busy), 16'(busy));
        check_eq("rd_rdy", 16'(bus.rd_rdy), 16'(!busy));
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (busy) begin
            wa = 7'(128 - init_left);
            check_eq("init_wr_act", 16'(ary_wr_act), 16'd1);
            check_eq("init_wr_adr", 16'(ary_wr_adr), 16'(wa));
            check_eq("init_bw", ary_bw, 16'hFFFF);
            check_eq("init_di", ary_di, INIT_VAL);
            shadow[wa] = INIT_VAL;
        end else begin
            m_g1 = bus.wr1_req && (deny == int'(STARVE_MAX) || !bus.wr0_req);
            m_g0 = bus.wr0_req && !m_g1;
            wa = m_g1 ? bus.wr1_adr : bus.wr0_adr;
            wb = m_g1 ? bus.wr1_bw  : bus.wr0_bw;
            wd = m_g1 ? bus.wr1_di  : bus.wr0_di;
            wact = (m_g0 || m_g1) && (wb != 16'h0);
            check_eq("wr_act", 16'(ary_wr_act), 16'(wact));
            if (wact) begin
                check_eq("wr_adr", 16'(ary_wr_adr), 16'(wa));
                check_eq("wr_bw", ary_bw, wb);
                check_eq("wr_di", ary_di, wd);
                shadow[wa] = (shadow[wa] & ~wb) | (wd & wb);
            end
        end
        check_eq("wr0_gnt", 16'(bus.wr0_gnt), 16'(m_g0));
        check_eq("wr1_gnt", 16'(bus.wr1_gnt), 16'(m_g1));
        dut_g1 = bus.wr1_gnt;

        racc = !busy && bus.rd_req;
        check_eq("rd_act", 16'(ary_rd_act), 16'(racc));
        if (racc) begin
            check_eq("rd_adr", 16'(ary_rd_adr), 16'(bus.rd_adr));
            if (cyc + int'(RD_LAT) + 1 < MAXC) begin
                exp_vld[cyc + RD_LAT + 1] = 1'b1;
                exp_dat[cyc + RD_LAT + 1] = shadow[bus.rd_adr];
            end
        end
        check_eq("rd_val", 16'(bus.rd_val), 16'(exp_vld[cyc]));
        if (exp_vld[cyc]) check_eq("rd_data", bus.rd_data, exp_dat[cyc]);

        if (busy) begin
            init_left--;
            deny = 0;
        end else begin
            if (bus.wr1_req && !m_g1) deny = (deny < int'(STARVE_MAX)) ? deny + 1 : deny;
            else deny = 0;
            if (bus.init_req) begin
                init_left = 128;
                deny      = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rst_tick();
        @(negedge clk);
        check_eq("rst_busy", 16'(bus.init_busy), 16'd1);
        check_eq("rst_rd_val", 16'(bus.rd_val), 16'd0);
        check_eq("rst_rd_data", bus.rd_data, 16'h0000);
        check_eq("rst_gnt0", 16'(bus.wr0_gnt), 16'd0);
        check_eq("rst_gnt1", 16'(bus.wr1_gnt), 16'd0);
        check_eq("rst_rd_act", 16'(ary_rd_act), 16'd0);
        check_eq("rst_wr_adr", 16'(ary_wr_adr), 16'd0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic new_wr0(input logic [6:0] a, input logic [15:0] b, input logic [15:0] d);
        bus.wr0_req = 1'b1; bus.wr0_adr = a; bus.wr0_bw = b; bus.wr0_di = d;
    endtask

    task automatic new_wr1(input logic [6:0] a, input logic [15:0] b, input logic [15:0] d);
        bus.wr1_req = 1'b1; bus.wr1_adr = a; bus.wr1_bw = b; bus.wr1_di = d;
    endtask

    function automatic logic [15:0] rnd_bw();
        return ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    endfunction

    initial begin
        logic [15:0] ghist;
        bit          any_g1;

        for (int i = 0; i < 128; i++) ary_mem[i] = 16'($urandom);
        bus.init_req = 1'b0;
        bus.wr0_req = 1'b0; bus.wr0_adr = '0; bus.wr0_bw = '0; bus.wr0_di = '0;
        bus.wr1_req = 1'b0; bus.wr1_adr = '0; bus.wr1_bw = '0; bus.wr1_di = '0;
        bus.rd_req = 1'b0; bus.rd_adr = '0;
        rst = 1'b1;
        init_left = 128;
        deny = 0;
        clear_future();

        // Reset and first sweep
        @(posedge clk);
        #1;
        rst_tick();
        rst_tick();
        rst = 1'b0;
        init_left = 128;
        deny = 0;
        repeat (129) tick();

        // Read of address 5 after the sweep
        bus.rd_req = 1'b1; bus.rd_adr = 7'd5;
        tick();
        bus.rd_req = 1'b0;
        tick();
        tick();
        check_eq("rd5_val", 16'(bus.rd_val), 16'd1);
        check_eq("rd5_data", bus.rd_data, 16'h0000);

        // Fixed priority with starvation guard
        new_wr0(7'(64 + $urandom_range(0, 31)), 16'hFFFF, 16'($urandom));
        new_wr1(7'(96 + $urandom_range(0, 31)), 16'hFFFF, 16'($urandom));
        ghist = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ghist[i] = dut_g1;
            if (m_g0) new_wr0(7'(64 + $urandom_range(0, 31)), 16'hFFFF, 16'($urandom));
            if (m_g1) new_wr1(7'(96 + $urandom_range(0, 31)), 16'hFFFF, 16'($urandom));
        end
        check_eq("prio_pattern", ghist, 16'h0210);

        // Dropping wr1 clears the starvation count
        tick();
        tick();
        bus.wr1_req = 1'b0;
        tick();
        bus.wr1_req = 1'b1;
        ghist = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ghist[i] = dut_g1;
            if (m_g1) bus.wr1_req = 1'b0;
        end
        check_eq("starve_clear", ghist, 16'h0010);
        bus.wr0_req = 1'b0;
        bus.wr1_req = 1'b0;
        tick();

        // Collision: same-cycle partial write and read of entry 10
        new_wr0(7'd10, 16'hFFFF, 16'hAAAA);
        tick();
        new_wr0(7'd10, 16'h00FF, 16'h1234);
        bus.rd_req = 1'b1; bus.rd_adr = 7'd10;
        tick();
        bus.wr0_req = 1'b0;
        tick();
        bus.rd_req = 1'b0;
        tick();
        check_eq("coll_data", bus.rd_data, 16'hAA34);
        tick();
        check_eq("after_coll_data", bus.rd_data, 16'hAA34);

        // Zero byte-enable write retires but leaves the entry alone
        new_wr0(7'd10, 16'h0000, 16'hFFFF);
        tick();
        bus.wr0_req = 1'b0;
        bus.rd_req = 1'b1; bus.rd_adr = 7'd10;
        tick();
        bus.rd_req = 1'b0;
        tick();
        tick();
        check_eq("zero_bw_data", bus.rd_data, 16'hAA34);

        // init_req with reads in flight and a pending wr1
        bus.rd_req = 1'b1; bus.rd_adr = 7'd20;
        tick();
        bus.rd_adr = 7'd10;
        tick();
        bus.rd_req = 1'b0;
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        new_wr1(7'd30, 16'h0000, 16'($urandom));
        any_g1 = 1'b0;
        for (int i = 0; i < 128; i++) begin
            tick();
            any_g1 = any_g1 | dut_g1;
        end
        check_eq("init_no_gnt", 16'(any_g1), 16'd0);
        tick();
        bus.wr1_req = 1'b0;
        for (int a = 0; a < 128; a++) begin
            bus.rd_req = 1'b1; bus.rd_adr = 7'(a);
            tick();
        end
        bus.rd_req = 1'b0;
        repeat (4) tick();

        // Random traffic on a small address range to provoke collisions
        for (int i = 0; i < 600; i++) begin
            if (!bus.wr0_req && $urandom_range(0, 1) == 1)
                new_wr0(7'($urandom_range(0, 7)), rnd_bw(), 16'($urandom));
            if (!bus.wr1_req && $urandom_range(0, 2) == 0)
                new_wr1(7'($urandom_range(0, 7)), rnd_bw(), 16'($urandom));
            bus.rd_req   = ($urandom_range(0, 1) == 1);
            bus.rd_adr   = 7'($urandom_range(0, 7));
            bus.init_req = ($urandom_range(0, 199) == 0);
            tick();
            if (m_g0) bus.wr0_req = 1'b0;
            if (m_g1) bus.wr1_req = 1'b0;
        end
        bus.init_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.wr0_req = 1'b0;
        bus.wr1_req = 1'b0;
        repeat (140) tick();

        // Reset in the middle of a sweep
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        repeat (60) tick();
        rst = 1'b1;
        clear_future();
        rst_tick();
        rst = 1'b0;
        init_left = 128;
        deny = 0;
        repeat (129) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_128x16_1r1w_ctl.md
Name: tri_128x16_1r1w_ctl

Overview:
- Sequencing and arbitration controller in front of one 128-entry x 16-bit, 1-read/1-write array.
- After reset, or on request, sweeps all 128 entries to INIT_VAL.
- Arbitrates the single write port between two requesters using fixed priority with a starvation guard.
- Issues reads, pipelines the returned data with fixed latency, and merges a same-cycle colliding write into the read data (write-before-read semantics).

Parameters:
- INIT_VAL, 16'h0000, value written to every entry during an init sweep.
- RD_LAT, 2, cycles from ary_rd_act until ary_do is valid; must be >= 1.
- STARVE_MAX, 4, consecutive denied cycles after which wr1 wins over wr0; must be >= 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- init_req  in  1  pulse; restarts the init sweep (ignored while already in INIT).
- init_busy  out  1  high while sweep in progress.
- wr0_req / wr1_req  in  1  write requests; requester holds until granted.
- wr0_adr / wr1_adr  in  7  write address.
- wr0_bw / wr1_bw  in  16  per-bit write enables.
- wr0_di / wr1_di  in  16  write data.
- wr0_gnt / wr1_gnt  out  1  combinational grant; write commits this cycle.
- rd_req  in  1  read request (single-cycle command, no back-pressure).
- rd_adr  in  7  read address.
- rd_rdy  out  1  equals ~init_busy; rd_req is dropped when rd_rdy=0.
- rd_val  out  1  registered; read data valid.
- rd_data  out  16  registered; read data.
- ary_wr_act  out  1  array write enable.
- ary_wr_adr  out  7  array write address.
- ary_bw  out  16  array bit write enables.
- ary_di  out  16  array write data.
- ary_rd_act  out  1  array read enable.
- ary_rd_adr  out  7  array read address.
- ary_do  in  16  array read data, valid RD_LAT cycles after ary_rd_act.

Behaviour:
- FSM states: INIT, RUN.
  - rst -> INIT with init_cnt=0.
  - INIT: each cycle drive ary_wr_act=1, ary_wr_adr=init_cnt, ary_bw=16'hFFFF, ary_di=INIT_VAL; increment init_cnt. After the write of address 127, next state is RUN.
  - RUN + init_req -> INIT with init_cnt=0.
  - rst mid-sweep restarts the sweep at 0.
- Reset values:
  - init_busy=1, rd_val=0, rd_data=0, wr0_gnt=wr1_gnt=0, ary_rd_act=0.
  - Array write outputs show the INIT address-0 write; this is harmless and idempotent.
- INIT:
  - No write grants; requesters hold their requests.
  - rd_rdy=0 and rd_req is ignored.
  - Reads already in the pipeline still complete with valid data.
- RUN write arbitration:
  - wr0 wins unless starve_cnt==STARVE_MAX and wr1_req=1, in which case wr1 wins.
  - starve_cnt increments (saturating at STARVE_MAX) when wr1_req=1 and wr1_gnt=0.
  - starve_cnt clears when wr1_gnt=1 or wr1_req=0, and clears on entering INIT.
  - At most one grant per cycle.
  - The granted requester's adr/bw/di drive the ary_* write outputs; ary_wr_act = grant & (bw != 0).
  - A grant with bw=0 still retires the request but writes nothing.
- Reads:
  - Accepted in RUN the same cycle as rd_req: ary_rd_act=1, ary_rd_adr=rd_adr.
  - Fully pipelined, one read per cycle, rd_val exactly RD_LAT+1 cycles after rd_req.
  - The pipeline carries valid, a collision flag, and the colliding bw and di.
- Collision:
  - Defined as an accepted read and an issued write in the same cycle to the same address.
  - Returned data: rd_data[i] = bw[i] ? di[i] : ary_do[i].
  - Writes in later cycles never affect an earlier read.
  - During INIT no reads are accepted, so init writes never collide.
- Back-to-back:
  - Write at cycle t is visible in the array to a read accepted at t+1 or later; no bypass is needed.
- Address wrap:
  - init_cnt is 7 bits.
  - The terminal condition is init_cnt==127 in INIT, not wrap to 0.

Decomposition:
- Shared package tri_ary_ctl_pkg:
  - constants ARY_ENTRIES=128, ARY_AW=7, ARY_DW=16;
  - FSM state enum {INIT, RUN};
  - read-pipeline stage struct {val, coll, bw, di}.
- One sub-module: tri_ary_rd_pipe, an RD_LAT-deep shift register of the stage struct plus the output merge and output register.
- Arbiter, starvation counter and init FSM stay in the top level.

Test Plan:
- Reset release:
  - init_busy=1 for exactly 128 cycles, with ary_wr_adr stepping 0..127, bw=FFFF, di=0.
  - Then init_busy=0 and rd_rdy=1.
  - Read of address 5 returns 16'h0000 with rd_val 3 cycles after rd_req (RD_LAT=2).
- Priority:
  - wr0 and wr1 both request continuously.
  - Grants follow wr0 x4, wr1 x1, wr0 x4, wr1 x1, …
  - Dropping wr1_req clears starve_cnt.
- Collision:
  - Entry 10 holds 16'hAAAA. Same cycle: write adr 10, bw=16'h00FF, di=16'h1234, plus read adr 10.
  - Read returns 16'hAA34.
  - A read of adr 10 on the next cycle returns 16'hAA34 from the array.
- Zero bw:
  - wr0_req with bw=0 gets wr0_gnt=1 and ary_wr_act=0; the entry is unchanged.
- init_req mid-traffic:
  - Two reads in flight, then init_req.
  - Both rd_val still return.
  - Pending wr1 gets no grant for 128 cycles.
  - Afterwards all entries read INIT_VAL.
- Reset mid-sweep:
  - rst pulsed at init_cnt=60.
  - Sweep restarts at address 0 and lasts the full 128 cycles.
  - rd_val=0 throughout.
